// File: rtl/slave_axi_writer_if.sv
//------------------------------------------------------------------------------
// Module   : slave_axi_writer_if
// Brief    : AXI AR/R channels plus bridge-engine beat request/return signals.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface slave_axi_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic                  eng_start;
  logic                  eng_busy;
  logic                  eng_req;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [2:0]            eng_size;
  logic                  eng_dvalid;
  logic [DATA_WIDTH-1:0] eng_rdata;
  logic [1:0]            eng_resp;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
           eng_start, eng_dvalid, eng_rdata, eng_resp,
    output arready, rid, rdata, rresp, rlast, rvalid,
           eng_busy, eng_req, eng_addr, eng_size
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
           eng_start, eng_dvalid, eng_rdata, eng_resp,
    input  arready, rid, rdata, rresp, rlast, rvalid,
           eng_busy, eng_req, eng_addr, eng_size
  );
endinterface

`default_nettype wire

// File: rtl/slave_axi_writer.sv
//------------------------------------------------------------------------------
// Module   : slave_axi_writer
// Brief    : AXI read-burst slave front end; fetches beats via the bridge engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module slave_axi_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  slave_axi_writer_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_R    = 3'd4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [2:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_wrap_ok;
  logic                  w_last;

  assign w_step    = ADDR_WIDTH'(1) << size_q;
  assign w_incr    = addr_q + w_step;
  assign w_mask    = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
  assign w_wrap_ok = (len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15);
  assign w_last    = (cnt_q == len_q);

  // WRAP with a non power-of-two beat count degrades to INCR, as does reserved
  always_comb begin
    w_next_addr = w_incr;
    if (burst_q == BURST_FIXED) begin
      w_next_addr = addr_q;
    end else if ((burst_q == BURST_WRAP) && w_wrap_ok) begin
      w_next_addr = (addr_q & ~w_mask) | (w_incr & w_mask);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (state_q)
      S_IDLE: begin
        if (bus.eng_start) state_d = S_AR;
      end
      S_AR: begin
        if (bus.arvalid) begin
          id_d    = bus.arid;
          addr_d  = bus.araddr;
          len_d   = bus.arlen;
          size_d  = bus.arsize;
          burst_d = bus.arburst;
          cnt_d   = 4'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_dvalid) begin
          rdata_d = bus.eng_rdata;
          rresp_d = (burst_q == BURST_RSVD) ? RESP_SLVERR : bus.eng_resp;
          state_d = S_R;
        end
      end
      S_R: begin
        if (bus.rready) begin
          if (w_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            addr_d  = w_next_addr;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign bus.arready  = (state_q == S_AR);
  assign bus.rvalid   = (state_q == S_R);
  assign bus.rlast    = (state_q == S_R) && w_last;
  assign bus.rid      = id_q;
  assign bus.rdata    = rdata_q;
  assign bus.rresp    = rresp_q;
  assign bus.eng_busy = (state_q != S_IDLE);
  assign bus.eng_req  = (state_q == S_REQ);
  assign bus.eng_addr = addr_q;
  assign bus.eng_size = size_q;

endmodule

`default_nettype wire

// File: tb/tb_slave_axi_writer.sv
//------------------------------------------------------------------------------
// Module   : tb_slave_axi_writer
// Brief    : Table-driven burst vectors with an R-channel scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_slave_axi_writer;

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [1:0]       eresp;
    logic [1:0]       xresp;
    logic [3:0][31:0] xaddr;
    logic [31:0]      dbase;
    int               dly;
    int               bp_beat;
    int               bp_cyc;
  } vec_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[10];

  slave_axi_writer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  slave_axi_writer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [1:0] eresp,
                               input logic [1:0] xresp, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] a2, input logic [31:0] a3, input logic [31:0] dbase,
                               input int dly, input int bp_beat, input int bp_cyc);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.eresp = eresp; v.xresp = xresp; v.xaddr = {a3, a2, a1, a0};
    v.dbase = dbase; v.dly = dly; v.bp_beat = bp_beat; v.bp_cyc = bp_cyc;
    return v;
  endfunction

  task automatic run_burst(input vec_t v);
    exp_t e;
    bus.eng_start = 1'b1;
    tick();
    bus.eng_start = 1'b0;
    check("arready_after_start", 32'(bus.arready), 32'd1);
    check("busy_in_ar", 32'(bus.eng_busy), 32'd1);
    bus.arid = v.id; bus.araddr = v.addr; bus.arlen = v.len;
    bus.arsize = v.size; bus.arburst = v.burst; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("arready_after_ar", 32'(bus.arready), 32'd0);
    for (int b = 0; b <= int'(v.len); b++) begin
      check("eng_req", 32'(bus.eng_req), 32'd1);
      check("eng_addr", bus.eng_addr, v.xaddr[b[1:0]]);
      check("eng_size", 32'(bus.eng_size), 32'(v.size));
      tick();
      check("eng_req_pulse", 32'(bus.eng_req), 32'd0);
      for (int d = 0; d < v.dly; d++) tick();
      check("rvalid_in_wait", 32'(bus.rvalid), 32'd0);
      bus.eng_dvalid = 1'b1;
      bus.eng_rdata = v.dbase + 32'(b);
      bus.eng_resp = v.eresp;
      e.id = v.id; e.data = v.dbase + 32'(b); e.resp = v.xresp; e.last = (b == int'(v.len));
      sb.push_back(e);
      tick();
      bus.eng_dvalid = 1'b0;
      bus.eng_rdata = 32'hA5A5A5A5;
      bus.eng_resp = 2'b11;
      if (b == v.bp_beat) begin
        for (int c = 0; c < v.bp_cyc; c++) begin
          check("bp_rvalid", 32'(bus.rvalid), 32'd1);
          check("bp_rdata", bus.rdata, sb[0].data);
          check("bp_rlast", 32'(bus.rlast), 32'(sb[0].last));
          check("bp_no_req", 32'(bus.eng_req), 32'd0);
          tick();
        end
      end
      check("rvalid", 32'(bus.rvalid), 32'd1);
      bus.rready = 1'b1;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
        e = sb.pop_front();
        check("rid", 32'(bus.rid), 32'(e.id));
        check("rdata", bus.rdata, e.data);
        check("rresp", 32'(bus.rresp), 32'(e.resp));
        check("rlast", 32'(bus.rlast), 32'(e.last));
      end
      tick();
      bus.rready = 1'b0;
    end
    check("busy_after_last", 32'(bus.eng_busy), 32'd0);
    check("rvalid_after_last", 32'(bus.rvalid), 32'd0);
    check("no_extra_req", 32'(bus.eng_req), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0; bus.eng_start = 1'b0;
    bus.eng_dvalid = 1'b0; bus.eng_rdata = '0; bus.eng_resp = '0;

    //            id     addr          len   sz    burst  eres  xres  a0            a1            a2            a3            dbase         dly bp  bpc
    vecs[0] = mkv(4'h3, 32'h40,       4'd0, 3'd2, 2'b01, 2'b00, 2'b00, 32'h40,       32'h0,        32'h0,  32'h0,   32'hDEADBEEF, 0, -1, 0);
    vecs[1] = mkv(4'h5, 32'h100,      4'd3, 3'd2, 2'b01, 2'b00, 2'b00, 32'h100,      32'h104,      32'h108, 32'h10C, 32'h11110000, 1, -1, 0);
    vecs[2] = mkv(4'h6, 32'h108,      4'd3, 3'd2, 2'b10, 2'b01, 2'b01, 32'h108,      32'h10C,      32'h100, 32'h104, 32'h22220000, 0, -1, 0);
    vecs[3] = mkv(4'h7, 32'h20,       4'd2, 3'd2, 2'b00, 2'b00, 2'b00, 32'h20,       32'h20,       32'h20,  32'h0,   32'h33330000, 2, -1, 0);
    vecs[4] = mkv(4'h8, 32'h200,      4'd1, 3'd2, 2'b11, 2'b00, 2'b10, 32'h200,      32'h204,      32'h0,   32'h0,   32'h44440000, 0, -1, 0);
    vecs[5] = mkv(4'h9, 32'h300,      4'd0, 3'd2, 2'b01, 2'b10, 2'b10, 32'h300,      32'h0,        32'h0,   32'h0,   32'h55550000, 0, -1, 0);
    vecs[6] = mkv(4'hA, 32'hFFFFFFFC, 4'd1, 3'd2, 2'b01, 2'b00, 2'b00, 32'hFFFFFFFC, 32'h0,        32'h0,   32'h0,   32'h66660000, 0, -1, 0);
    vecs[7] = mkv(4'hB, 32'h18,       4'd1, 3'd3, 2'b10, 2'b11, 2'b11, 32'h18,       32'h10,       32'h0,   32'h0,   32'h77770000, 1, -1, 0);
    vecs[8] = mkv(4'hC, 32'h7,        4'd2, 3'd0, 2'b10, 2'b00, 2'b00, 32'h7,        32'h8,        32'h9,   32'h0,   32'h88880000, 0, -1, 0);
    vecs[9] = mkv(4'hF, 32'h1000,     4'd3, 3'd2, 2'b01, 2'b00, 2'b00, 32'h1000,     32'h1004,     32'h1008, 32'h100C, 32'h99990000, 0, 1, 5);

    tick();
    tick();
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_busy", 32'(bus.eng_busy), 32'd0);
    check("rst_req", 32'(bus.eng_req), 32'd0);
    check("rst_rlast", 32'(bus.rlast), 32'd0);
    check("rst_addr", bus.eng_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    // back-to-back bursts: each eng_start lands in the cycle right after the last handshake
    for (int i = 0; i < 10; i++) run_burst(vecs[i]);

    // reset in WAIT of beat 2 of an INCR burst
    bus.eng_start = 1'b1;
    tick();
    bus.eng_start = 1'b0;
    bus.arid = 4'hD; bus.araddr = 32'h500; bus.arlen = 4'd3; bus.arsize = 3'd2;
    bus.arburst = 2'b01; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    tick();
    bus.eng_dvalid = 1'b1; bus.eng_rdata = 32'hCAFEF00D; bus.eng_resp = 2'b01;
    tick();
    bus.eng_dvalid = 1'b0;
    check("mid_rvalid", 32'(bus.rvalid), 32'd1);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("mid_req_beat2", 32'(bus.eng_req), 32'd1);
    check("mid_addr_beat2", bus.eng_addr, 32'h504);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_arready", 32'(bus.arready), 32'd0);
    check("abort_rid", 32'(bus.rid), 32'd0);
    check("abort_rdata", bus.rdata, 32'd0);
    check("abort_rresp", 32'(bus.rresp), 32'd0);
    check("abort_rlast", 32'(bus.rlast), 32'd0);
    check("abort_rvalid", 32'(bus.rvalid), 32'd0);
    check("abort_busy", 32'(bus.eng_busy), 32'd0);
    check("abort_req", 32'(bus.eng_req), 32'd0);
    check("abort_addr", bus.eng_addr, 32'd0);
    check("abort_size", 32'(bus.eng_size), 32'd0);
    tick();
    tick();
    check("abort_req_held", 32'(bus.eng_req), 32'd0);
    rst_n = 1'b1;
    bus.eng_dvalid = 1'b1; bus.eng_rdata = 32'h12345678;
    tick();
    bus.eng_dvalid = 1'b0;
    tick();
    check("stray_dvalid_rvalid", 32'(bus.rvalid), 32'd0);
    check("stray_dvalid_busy", 32'(bus.eng_busy), 32'd0);
    sb.delete();
    run_burst(vecs[0]);
    run_burst(vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/slave_axi_writer.md
# slave_axi_writer

Read-direction slave front end of the AXI2APB bridge. Accepts one AXI read burst on the AR channel, requests each beat from the bridge engine (which performs the APB read), and returns the beats on the R channel with correct `rid`, `rresp` and `rlast`. It complements the write-channel slave front end (AW/W/B): the engine starts it, then waits for it to return to idle.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AXI/engine address width.
- `DATA_WIDTH`, 32: AXI/engine data width.
- `ID_WIDTH`, 4: AXI ID width.

Ports:
- Clock and reset: clock `clk`; reset `rst_n`, asynchronous, active-low.
- `arid` in, ID_WIDTH: read address ID.
- `araddr` in, ADDR_WIDTH: burst start address.
- `arlen` in, 4: beats minus 1.
- `arsize` in, 3: bytes per beat = 1<<arsize.
- `arburst` in, 2: burst type. 00 = FIXED, 01 = INCR, 10 = WRAP, 11 = reserved.
- `arvalid` in, 1; `arready` out, 1: AR handshake.
- `rid` out, ID_WIDTH: captured `arid`.
- `rdata` out, DATA_WIDTH: beat data.
- `rresp` out, 2: beat response.
- `rlast` out, 1: final beat.
- `rvalid` out, 1; `rready` in, 1: R handshake.
- `eng_start` in, 1: engine grants this block one burst.
- `eng_busy` out, 1: high in every state except IDLE.
- `eng_req` out, 1: one-cycle request for a beat.
- `eng_addr` out, ADDR_WIDTH: address of the requested beat.
- `eng_size` out, 3: captured `arsize`.
- `eng_dvalid` in, 1: engine returns beat data.
- `eng_rdata` in, DATA_WIDTH: returned beat data.
- `eng_resp` in, 2: returned beat response.

## Operation
States: IDLE, AR, REQ, WAIT, R.

- **IDLE**
  - Outputs: `arready`=0, `rvalid`=0.
  - `eng_start`=1 → AR. `eng_start` is ignored in every other state.
- **AR**
  - Outputs: `arready`=1.
  - On `arvalid`: capture id/addr/len/size/burst, clear beat counter `cnt`(4b), → REQ.
- **REQ**
  - Outputs: `eng_req`=1 for exactly one cycle; `eng_addr` = current beat address.
  - → WAIT.
- **WAIT**
  - On `eng_dvalid`: register `eng_rdata` and response into a holding register, → R.
  - `eng_dvalid` in any other state is ignored.
- **R**
  - Outputs: `rvalid`=1; `rlast` = (`cnt`==len).
  - On `rready` with `rlast`: → IDLE.
  - On `rready` without `rlast`: `cnt`+1, advance address, → REQ.
- Address advance, with step = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr + step, width ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH.
  - WRAP with len ∈ {1,3,7,15}: mask = ((len+1)<<size)−1; next = (addr & ~mask) | ((addr+step) & mask).
  - WRAP with any other len: treated as INCR.
- Reserved burst (11): addresses advance as INCR, but `rresp` is forced to 2'b10 (SLVERR) on every beat regardless of `eng_resp`. All other burst types pass `eng_resp` through unchanged.
- `eng_addr` holds the current beat address in all states. `eng_size` and `rid` hold the captured values until the next AR capture.

## Timing
- Reset value of every output is 0: `arready`, `rid`, `rdata`, `rresp`, `rlast`, `rvalid`, `eng_busy`, `eng_req`, `eng_addr`, `eng_size`. State returns to IDLE.
- Reset asserted mid-burst aborts the burst immediately. No R beat is completed and no further `eng_req` is issued.
- Latencies:
  - `eng_start` at cycle N → `arready` high at N+1.
  - AR handshake at cycle N → `eng_req` at N+1.
  - `eng_dvalid` at cycle M → `rvalid` at M+1.
  - R handshake (not last) at cycle K → next `eng_req` at K+1.
- `rdata`, `rresp`, `rlast` and `rid` stay stable while `rvalid`=1 and `rready`=0. `rvalid` never drops before the handshake.
- `rvalid`=0 and `arready`=0 at all times outside R and AR respectively.
- Last-beat handshake at cycle K: IDLE, `eng_busy`=0 at K+1. `eng_start` at K+1 is accepted.
- Each burst issues exactly len+1 `eng_req` pulses and produces exactly len+1 R beats.

## Test plan
- **Single beat:** `eng_start`; AR id=3, addr=0x40, len=0, INCR; engine returns 0xDEADBEEF with resp 00 → one R beat: rid=3, rdata=0xDEADBEEF, rresp=00, rlast=1. Then IDLE.
- **INCR:** len=3, size=2, addr=0x100 → `eng_addr` sequence 0x100, 0x104, 0x108, 0x10C; `rlast` only on beat 4.
- **WRAP:** len=3, size=2, addr=0x108 → `eng_addr` sequence 0x108, 0x10C, 0x100, 0x104. FIXED, len=2, addr=0x20 → 0x20 three times.
- **Backpressure:** `rready` held low for 5 cycles on beat 2 of 4 → `rdata`/`rlast` stable throughout; no `eng_req` until the handshake; the next `eng_req` comes one cycle after it.
- **Reserved burst:** `arburst`=11, len=1, `eng_resp`=00 → both beats rresp=10, addresses advance as INCR. Separately, engine resp=10 on an INCR beat → passed through as rresp=10.
- **Reset mid-burst:** assert `rst_n`=0 in WAIT of beat 2 → all outputs 0. After release, a new `eng_start` and AR complete normally; a stray `eng_dvalid` in IDLE is ignored.
